module_divisor: RTL and testbench
=================================

Name: module_divisor

Overview:
- Sequential restoring divider: the inverse operation of the Booth multiplier in the calculator datapath.
- Takes the two binary operands produced by the keypad/BCD-to-binary stage, on the same valid/done handshake as the multiplier.
- Produces an unsigned quotient and remainder, one quotient bit per clock.
- Its results feed the priority mux, then binary-to-BCD, then the 7-segment display.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- valid  input  1  start request; sampled only in IDLE.
- dividendo  input  WIDTH  dividend operand.
- divisor  input  WIDTH  divisor operand.
- cociente  output  WIDTH  registered quotient.
- residuo  output  WIDTH  registered remainder.
- done  output  1  one-cycle pulse: result valid.
- busy  output  1  high while a division is in progress (CALC or DONE).
- div_cero  output  1  registered flag: last operation had divisor == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
  - rst == 0 at a clock edge forces state IDLE and clears every output: cociente=0, residuo=0, done=0, busy=0, div_cero=0.
  - Internal registers are also cleared.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, valid == 1 at edge E0:
  - Latch dividendo into Q and divisor into D; clear partial remainder R (WIDTH+1 bits); iteration counter = WIDTH.
  - If divisor != 0: go to CALC.
  - If divisor == 0: go to DONE, with cociente = all ones, residuo = dividendo, div_cero = 1.
- IDLE, valid == 0: stay in IDLE; outputs hold.
- CALC, each edge:
  - {R,Q} shifted left one bit; trial T = R - D computed at WIDTH+1 bits.
  - If T >= 0: R = T and Q[0] = 1. Otherwise R is kept (restored) and Q[0] = 0.
  - Counter decrements.
  - On the edge where the counter reaches 0 (edge E_WIDTH): cociente = Q, residuo = R[WIDTH-1:0], div_cero = 0; go to DONE.
- DONE:
  - done = 1 for exactly this one cycle; next edge returns to IDLE.
  - done is visible after edge E_WIDTH, i.e. a latency of WIDTH cycles from the sampling edge; 1 cycle for divide-by-zero.
- busy: 1 in CALC and DONE, 0 in IDLE.
- Boundary conditions:
  - valid asserted while busy is ignored; operand changes during CALC have no effect.
  - valid held high continuously: a new division starts on the first IDLE edge after DONE.
  - cociente, residuo and div_cero hold their value until the next completed operation or reset.
  - dividendo < divisor: cociente = 0, residuo = dividendo.
  - dividendo == 0: cociente = 0, residuo = 0, full latency.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are divided by the same unsigned core.
  - Quotient is negated when the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Sign fix-up is applied on the DONE-entry edge, with no added latency.
  - -2^(WIDTH-1) / -1 yields cociente = 2^(WIDTH-1) bit pattern (0x80 for WIDTH=8) and residuo = 0.
  - Divide-by-zero gives cociente = all ones, residuo = dividendo, as in unsigned mode.
- Undefined: purely unsigned, no sign logic synthesised.

Decomposition:
- Package pkg_divisor holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - the default WIDTH constant;
  - the localparam for the divide-by-zero quotient pattern (all ones).
- One natural sub-module: module_div_paso.
  - Combinational single iteration: inputs R, Q MSB and D.
  - Outputs the next R and the quotient bit.
  - Instantiated once inside the CALC datapath.

Test Plan:
- Reset, then dividendo=100, divisor=7, valid pulse → exactly 8 cycles later: cociente=14, residuo=2, done high for one cycle, div_cero=0.
- dividendo=255, divisor=1 → cociente=255, residuo=0; then dividendo=5, divisor=9 → cociente=0, residuo=5.
- dividendo=42, divisor=0 → done after 1 cycle: cociente=255, residuo=42, div_cero=1; busy low the following cycle.
- Pulse valid again 3 cycles into a division of 200/3, with different operands → ignored; result cociente=66, residuo=2; only one done pulse.
- Drive rst low at cycle 4 of a division of 99/4 → all outputs 0, no done pulse; restart the same division → cociente=24, residuo=3.
- With DIV_SIGNED_EN:
  - -100 / 7 → cociente=-14 (0xF2), residuo=-2 (0xFE);
  - -128 / -1 → cociente=0x80, residuo=0.

Source files
------------

// File: rtl/module_divisor_pkg.sv
// Shared types and constants for the restoring divider.
package pkg_divisor;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 8;

    // Divide-by-zero quotient: all ones, sliced down to the instance width.
    localparam logic [63:0] COC_DIV_CERO = '1;

endpackage

// File: rtl/module_divisor_paso.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module module_div_paso
    import pkg_divisor::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;

    assign r_sh   = {r, q_msb};
    assign trial  = r_sh - {2'b00, d};
    assign q_bit  = ~trial[WIDTH+1];
    assign r_next = q_bit ? trial[WIDTH:0] : r_sh[WIDTH:0];

endmodule

// File: rtl/module_divisor.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncation toward zero).
module module_divisor
    import pkg_divisor::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] residuo,
    output logic             done,
    output logic             busy,
    output logic             div_cero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    module_div_paso #(.WIDTH(WIDTH)) u_paso (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (r_nxt),
        .q_bit  (q_bit)
    );

    assign q_nxt = {q_q[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Core divides magnitudes; signs are restored on the DONE-entry edge.
    assign mag_a = dividendo[WIDTH-1] ? WIDTH'(-dividendo) : dividendo;
    assign mag_b = divisor[WIDTH-1]   ? WIDTH'(-divisor)   : divisor;
    assign res_q = neg_q ? WIDTH'(-q_nxt) : q_nxt;
    assign res_r = neg_r ? WIDTH'(-r_nxt[WIDTH-1:0]) : r_nxt[WIDTH-1:0];
`else
    assign mag_a = dividendo;
    assign mag_b = divisor;
    assign res_q = q_nxt;
    assign res_r = r_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (valid) state_next = (divisor == '0) ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt      <= '0;
            cociente <= '0;
            residuo  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            div_cero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done <= (state_next == DONE);
            busy <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        q_q <= mag_a;
                        d_q <= mag_b;
                        r_q <= '0;
                        cnt <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
                        neg_q <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividendo[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            cociente <= COC_DIV_CERO[WIDTH-1:0];
                            residuo  <= dividendo;
                            div_cero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        cociente <= res_q;
                        residuo  <= res_r;
                        div_cero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_divisor.sv
// Self-checking bench for module_divisor; follows DIV_SIGNED_EN like the RTL.
module tb_module_divisor;

    localparam int W   = 8;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [W-1:0] dividendo;
    logic [W-1:0] divisor;
    logic [W-1:0] cociente;
    logic [W-1:0] residuo;
    logic         done;
    logic         busy;
    logic         div_cero;

    int checks   = 0;
    int failures = 0;

    module_divisor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .dividendo (dividendo),
        .divisor   (divisor),
        .cociente  (cociente),
        .residuo   (residuo),
        .done      (done),
        .busy      (busy),
        .div_cero  (div_cero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division (SV int '/' and '%' truncate toward zero).
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz, output int lat);
        int ia, ib;
        if (b == 0) begin
            q = {W{1'b1}}; r = a; dz = 1'b1; lat = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            ia = int'($signed(a));
            ib = int'($signed(b));
`else
            ia = int'(a);
            ib = int'(b);
`endif
            q = W'(ia / ib); r = W'(ia % ib); dz = 1'b0; lat = W;
        end
    endfunction

    // Pulse valid for one edge; lat = edges after the sampling edge until done (-1 on timeout).
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        dividendo = a; divisor = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b0; dividendo = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cociente !== '0) begin failures++; $display("FAIL reset_cociente got=%h exp=00", cociente); end
        checks++; if (residuo !== '0) begin failures++; $display("FAIL reset_residuo got=%h exp=00", residuo); end
        checks++; if ({done, busy, div_cero} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, busy, div_cero}); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] a_l [4] = '{8'd100, 8'd255, 8'd5, 8'd0};
        logic [W-1:0] b_l [4] = '{8'd7,   8'd1,   8'd9, 8'd13};
        logic [W-1:0] eq, er;
        logic edz;
        int elat, lat;
        for (int i = 0; i < 4; i++) begin
            ref_div(a_l[i], b_l[i], eq, er, edz, elat);
            start_and_wait(a_l[i], b_l[i], lat);
            checks++; if (lat !== elat) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, elat); end
            checks++; if ({cociente, residuo, div_cero} !== {eq, er, edz}) begin failures++;
                $display("FAIL dir_result[%0d] got=%h/%h/%b exp=%h/%h/%b", i, cociente, residuo, div_cero, eq, er, edz); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir_done_pulse[%0d] got=%b exp=0", i, done); end
            repeat (3) @(posedge clk);
            #1;
            checks++; if ({cociente, residuo} !== {eq, er}) begin failures++;
                $display("FAIL dir_hold[%0d] got=%h/%h exp=%h/%h", i, cociente, residuo, eq, er); end
        end
`ifndef DIV_SIGNED_EN
        start_and_wait(8'd100, 8'd7, lat);
        checks++; if ({cociente, residuo} !== {8'd14, 8'd2}) begin failures++;
            $display("FAIL plan_100_7 got=%0d/%0d exp=14/2", cociente, residuo); end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_div_zero();
        int lat;
        start_and_wait(8'd42, 8'd0, lat);
        checks++; if (lat !== 0) begin failures++; $display("FAIL dz_latency got=%0d exp=0", lat); end
        checks++; if ({cociente, residuo, div_cero} !== {8'hFF, 8'd42, 1'b1}) begin failures++;
            $display("FAIL dz_result got=%h/%h/%b exp=ff/2a/1", cociente, residuo, div_cero); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL dz_busy_after got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] eq, er;
        logic edz;
        int elat, n_done, cyc, done_cyc;
        logic [W-1:0] gq, gr;
        ref_div(8'd200, 8'd3, eq, er, edz, elat);
        dividendo = 8'd200; divisor = 8'd3; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_done = 0; done_cyc = -1; gq = '0; gr = '0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin valid = 1'b1; dividendo = 8'd17; divisor = 8'd5; end
            if (cyc == 4) valid = 1'b0;
            @(posedge clk); #1;
            if (cyc == 3) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
            end
            if (done === 1'b1) begin n_done++; done_cyc = cyc; gq = cociente; gr = residuo; end
        end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
        checks++; if (done_cyc !== W) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", done_cyc, W); end
        checks++; if ({gq, gr} !== {eq, er}) begin failures++; $display("FAIL ign_result got=%h/%h exp=%h/%h", gq, gr, eq, er); end
    endtask

    task automatic test_reset_abort();
        int lat, n_done;
        dividendo = 8'd99; divisor = 8'd4; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if ({cociente, residuo, done, busy, div_cero} !== '0) begin failures++;
            $display("FAIL abort_clear got=%h/%h/%b%b%b exp=0", cociente, residuo, done, busy, div_cero); end
        n_done = 0;
        repeat (12) begin @(posedge clk); #1; if (done === 1'b1) n_done++; end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        start_and_wait(8'd99, 8'd4, lat);
        checks++; if ({cociente, residuo, lat} !== {8'd24, 8'd3, W}) begin failures++;
            $display("FAIL abort_restart got=%0d/%0d lat=%0d exp=24/3 lat=%0d", cociente, residuo, lat, W); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eq, er;
        logic edz;
        int elat, n;
        dividendo = 8'd77; divisor = 8'd6; valid = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < TMO) begin @(posedge clk); #1; n++; end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_first_timeout got=%b exp=1", done); end
        ref_div(8'd77, 8'd6, eq, er, edz, elat);
        checks++; if ({cociente, residuo} !== {eq, er}) begin failures++;
            $display("FAIL b2b_first got=%h/%h exp=%h/%h", cociente, residuo, eq, er); end
        dividendo = 8'd250; divisor = 8'd11;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < TMO);
        valid = 1'b0;
        ref_div(8'd250, 8'd11, eq, er, edz, elat);
        checks++; if (n !== W + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", n, W + 2); end
        checks++; if ({cociente, residuo} !== {eq, er}) begin failures++;
            $display("FAIL b2b_second got=%h/%h exp=%h/%h", cociente, residuo, eq, er); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic edz;
        int elat, lat;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 3));
                2:       b = W'(a + 8'd1);
                default: b = W'($urandom_range(0, 255));
            endcase
            ref_div(a, b, eq, er, edz, elat);
            start_and_wait(a, b, lat);
            checks++; if (lat !== elat || {cociente, residuo, div_cero} !== {eq, er, edz}) begin failures++;
                $display("FAIL rand[%0d] %h/%h got=%h/%h/%b lat=%0d exp=%h/%h/%b lat=%0d",
                         i, a, b, cociente, residuo, div_cero, lat, eq, er, edz, elat); end
            @(posedge clk); #1;
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat;
        start_and_wait(8'h9C, 8'd7, lat);
        checks++; if ({cociente, residuo} !== {8'hF2, 8'hFE}) begin failures++;
            $display("FAIL sgn_m100_7 got=%h/%h exp=f2/fe", cociente, residuo); end
        @(posedge clk); #1;
        start_and_wait(8'h80, 8'hFF, lat);
        checks++; if ({cociente, residuo, lat} !== {8'h80, 8'h00, W}) begin failures++;
            $display("FAIL sgn_m128_m1 got=%h/%h lat=%0d exp=80/00 lat=%0d", cociente, residuo, lat, W); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
